// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Read hits return data the same cycle; read misses fill a 4-word line;
// stores write a single word through to memory and update a resident line.
module dcache_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int INDEX_W = 5,
   parameter int CNT_W   = 16
)(
   input  logic              clk,
   input  logic              RST,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic              flush,
   output logic [31:0]       cpu_rdata,
   output logic              stall,
   output logic              mem_rd_en,
   output logic              mem_miss,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [127:0]      mem_rdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int TAG_W = ADDR_W - INDEX_W - 2;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;
   state_t state, state_n;

   logic [3:0][31:0]   data_arr [LINES];
   logic [TAG_W-1:0]   tag_arr  [LINES];
   logic [LINES-1:0]   valid;
   // first IDLE cycle after a fill: the refilled load was already counted as a miss
   logic               skip_hit;

   logic [1:0]         cpu_off, mem_off;
   logic [INDEX_W-1:0] cpu_idx, mem_idx;
   logic [TAG_W-1:0]   cpu_tag, mem_tag;
   logic               hit, mem_hit;

   assign cpu_off = cpu_addr[1:0];
   assign cpu_idx = cpu_addr[INDEX_W+1:2];
   assign cpu_tag = cpu_addr[ADDR_W-1:INDEX_W+2];
   // in-flight transactions use the registered address, not the held core address
   assign mem_off = mem_addr[1:0];
   assign mem_idx = mem_addr[INDEX_W+1:2];
   assign mem_tag = mem_addr[ADDR_W-1:INDEX_W+2];
   assign hit     = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
   assign mem_hit = valid[mem_idx] && (tag_arr[mem_idx] == mem_tag);

   // next state, stall and load data
   always_comb begin
      state_n   = state;
      stall     = 1'b0;
      cpu_rdata = '0;
      case (state)
         IDLE: begin
            if (cpu_wr) begin
               state_n = WRITE;
               stall   = 1'b1;
            end else if (cpu_rd && !hit) begin
               state_n = FILL;
               stall   = 1'b1;
            end
            if (cpu_rd && hit) cpu_rdata = data_arr[cpu_idx][cpu_off];
         end
         FILL: begin
            stall = 1'b1;
            if (mem_ready) state_n = IDLE;
         end
         WRITE: begin
            stall = 1'b1;
            if (mem_ready) state_n = WDONE;
         end
         default: state_n = IDLE;
      endcase
   end

   // state, memory request registers, valid bits and saturating counters
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         valid     <= '0;
         skip_hit  <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_miss  <= 1'b0;
         mem_wr_en <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         state    <= state_n;
         skip_hit <= (state == FILL) && mem_ready;
         case (state)
            IDLE: begin
               if (cpu_wr) begin
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
                  mem_wr_en <= 1'b1;
               end else if (cpu_rd) begin
                  if (hit) begin
                     if (!skip_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                  end else begin
                     mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                     mem_rd_en <= 1'b1;
                     mem_miss  <= 1'b1;
                     if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                  end
               end else if (flush) begin
                  valid <= '0;
               end
            end
            FILL: if (mem_ready) begin
               mem_rd_en      <= 1'b0;
               mem_miss       <= 1'b0;
               valid[mem_idx] <= 1'b1;
            end
            WRITE: if (mem_ready) mem_wr_en <= 1'b0;
            default: ;
         endcase
      end
   end

   // tag/data arrays carry no reset; valid bits guard them
   always_ff @(posedge clk) begin
      if (state == FILL && mem_ready) begin
         data_arr[mem_idx] <= mem_rdata;
         tag_arr[mem_idx]  <= mem_tag;
      end
      if (state == WRITE && mem_ready && mem_hit)
         data_arr[mem_idx][mem_off] <= mem_wdata;
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a table of load/store/flush operations with
// hand-computed results, a simple word memory standing in for the data memory,
// and hand-written sequences for reset-in-fill and counter saturation.
module tb_dcache_ctrl;
   logic         clk = 1'b0;
   logic         RST;
   logic         cpu_rd, cpu_wr, flush, mem_ready;
   logic [9:0]   cpu_addr;
   logic [31:0]  cpu_wdata;
   logic [127:0] mem_rdata;
   logic [31:0]  cpu_rdata, mem_wdata;
   logic         stall, mem_rd_en, mem_miss, mem_wr_en;
   logic [9:0]   mem_addr;
   logic [15:0]  hit_cnt, miss_cnt;
   // narrow-counter instance for saturation
   logic [31:0]  s_rdata, s_wdata;
   logic         s_stall, s_rd_en, s_miss, s_wr_en;
   logic [9:0]   s_addr;
   logic [1:0]   s_hit_cnt, s_miss_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [1024];

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk(clk), .RST(RST), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .flush(flush), .cpu_rdata(cpu_rdata), .stall(stall),
      .mem_rd_en(mem_rd_en), .mem_miss(mem_miss), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   dcache_ctrl #(.CNT_W(2)) dut_s (
      .clk(clk), .RST(RST), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .flush(flush), .cpu_rdata(s_rdata), .stall(s_stall),
      .mem_rd_en(s_rd_en), .mem_miss(s_miss), .mem_wr_en(s_wr_en),
      .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt));

   typedef enum logic [1:0] {OP_LD, OP_ST, OP_STRD, OP_FL} op_t;
   typedef struct {
      op_t         op;
      logic [9:0]  addr;
      logic [31:0] wdata;
      int          lat;
      logic        exp_miss;
      logic [31:0] exp_rdata;
      logic [15:0] exp_hit;
      logic [15:0] exp_misses;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // wait lat cycles in the current memory transaction, then pulse mem_ready
   task automatic mem_respond(input int lat, input logic [9:0] base);
      for (int i = 0; i < lat - 1; i++) begin
         @(posedge clk); #1;
      end
      mem_rdata = {mem[base+3], mem[base+2], mem[base+1], mem[base]};
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [9:0] base;
      base = {v.addr[9:2], 2'b00};
      @(negedge clk);
      case (v.op)
         OP_LD: begin
            cpu_rd = 1'b1; cpu_addr = v.addr; #1;
            if (v.exp_miss) begin
               chk("miss_stall", stall, 1);
               @(posedge clk); #1;
               chk("fill_rd_en", mem_rd_en, 1);
               chk("fill_miss", mem_miss, 1);
               chk("fill_addr", mem_addr, base);
               chk("fill_stall", stall, 1);
               mem_respond(v.lat, base);
               chk("fill_done_rd_en", mem_rd_en, 0);
            end
            chk("ld_stall", stall, 0);
            chk("ld_rdata", cpu_rdata, v.exp_rdata);
            chk("ld_no_rd_en", mem_rd_en, 0);
            @(posedge clk); #1;
            cpu_rd = 1'b0;
         end
         OP_ST, OP_STRD: begin
            cpu_wr = 1'b1; cpu_rd = (v.op == OP_STRD);
            cpu_addr = v.addr; cpu_wdata = v.wdata; #1;
            chk("st_stall", stall, 1);
            @(posedge clk); #1;
            chk("st_wr_en", mem_wr_en, 1);
            chk("st_addr", mem_addr, v.addr);
            chk("st_wdata", mem_wdata, v.wdata);
            chk("st_no_rd_en", mem_rd_en, 0);
            chk("st_stall_held", stall, 1);
            mem[v.addr] = v.wdata;
            mem_respond(v.lat, base);
            chk("wdone_stall", stall, 0);
            chk("wdone_wr_en", mem_wr_en, 0);
            chk("wdone_no_rd_en", mem_rd_en, 0);
            cpu_wr = 1'b0; cpu_rd = 1'b0;
            @(posedge clk); #1;
         end
         default: begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
         end
      endcase
      chk("hit_cnt", hit_cnt, v.exp_hit);
      chk("miss_cnt", miss_cnt, v.exp_misses);
   endtask

   vec_t vecs [$];
   vec_t v;

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i) - 32'd3;
      // op, addr, wdata, lat, miss, rdata, hit_cnt, miss_cnt
      vecs.push_back('{OP_LD,   10'h004, 32'h0,        4, 1'b1, 32'h1,        16'd0, 16'd1});
      vecs.push_back('{OP_LD,   10'h005, 32'h0,        0, 1'b0, 32'h2,        16'd1, 16'd1});
      vecs.push_back('{OP_LD,   10'h007, 32'h0,        0, 1'b0, 32'h4,        16'd2, 16'd1});
      vecs.push_back('{OP_ST,   10'h006, 32'hDEADBEEF, 3, 1'b0, 32'h0,        16'd2, 16'd1});
      vecs.push_back('{OP_LD,   10'h006, 32'h0,        0, 1'b0, 32'hDEADBEEF, 16'd3, 16'd1});
      vecs.push_back('{OP_ST,   10'h084, 32'h12345678, 2, 1'b0, 32'h0,        16'd3, 16'd1});
      vecs.push_back('{OP_LD,   10'h004, 32'h0,        0, 1'b0, 32'h1,        16'd4, 16'd1});
      vecs.push_back('{OP_LD,   10'h084, 32'h0,        1, 1'b1, 32'h12345678, 16'd4, 16'd2});
      vecs.push_back('{OP_LD,   10'h004, 32'h0,        2, 1'b1, 32'h1,        16'd4, 16'd3});
      vecs.push_back('{OP_LD,   10'h006, 32'h0,        0, 1'b0, 32'hDEADBEEF, 16'd5, 16'd3});
      vecs.push_back('{OP_STRD, 10'h010, 32'hCAFE0001, 2, 1'b0, 32'h0,        16'd5, 16'd3});
      vecs.push_back('{OP_LD,   10'h010, 32'h0,        3, 1'b1, 32'hCAFE0001, 16'd5, 16'd4});
      vecs.push_back('{OP_FL,   10'h000, 32'h0,        0, 1'b0, 32'h0,        16'd5, 16'd4});
      vecs.push_back('{OP_LD,   10'h005, 32'h0,        5, 1'b1, 32'h2,        16'd5, 16'd5});
      vecs.push_back('{OP_LD,   10'h005, 32'h0,        0, 1'b0, 32'h2,        16'd6, 16'd5});

      RST = 1'b0; cpu_rd = 0; cpu_wr = 0; flush = 0; mem_ready = 0;
      cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
      #22;
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_counts", {hit_cnt, miss_cnt}, 0);
      chk("rst_stall", stall, 0);
      @(negedge clk); RST = 1'b1;

      // stray mem_ready in IDLE must not start anything
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      chk("idle_ready_rd", mem_rd_en, 0);
      chk("idle_ready_wr", mem_wr_en, 0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // 5 misses and 6 hits through a 2-bit counter instance
      chk("sat_miss", s_miss_cnt, 2'b11);
      chk("sat_hit", s_hit_cnt, 2'b11);

      // reset two cycles into a fill
      @(negedge clk); cpu_rd = 1'b1; cpu_addr = 10'h020;
      @(posedge clk); #1;
      chk("pre_rst_rd_en", mem_rd_en, 1);
      @(posedge clk); @(posedge clk); #1;
      RST = 1'b0; #1;
      chk("midrst_rd_en", mem_rd_en, 0);
      chk("midrst_miss", mem_miss, 0);
      chk("midrst_addr", mem_addr, 0);
      chk("midrst_counts", {hit_cnt, miss_cnt}, 0);
      cpu_rd = 1'b0;
      @(negedge clk); RST = 1'b1;
      v = '{OP_LD, 10'h020, 32'h0, 2, 1'b1, 32'h1D, 16'd0, 16'd1};
      run_vec(v);
      v = '{OP_LD, 10'h023, 32'h0, 0, 1'b0, 32'h20, 16'd1, 16'd1};
      run_vec(v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data-cache controller between the RISC-V core's load/store port and the word-addressed data memory.
- Holds tag/valid/data arrays and serves read hits in the same cycle.
- On a read miss, sequences a 4-word line fill from memory; on a store, sequences a single-word write-through.
- Stalls the core until each memory handshake completes and keeps saturating hit/miss counters.

Parameters:
ADDR_W, 10, word-address width (offset 2 b, index INDEX_W b, tag remainder)
INDEX_W, 5, index bits; 2^INDEX_W lines of 4 x 32-bit words
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-low reset
cpu_rd  in  1  load request, held until stall low
cpu_wr  in  1  store request, held until stall low
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  32  store data
flush  in  1  invalidate all lines (sampled in IDLE only)
cpu_rdata  out  32  load data, valid when cpu_rd & ~stall
stall  out  1  core must hold request and pipeline
mem_rd_en  out  1  line-read request to memory
mem_miss  out  1  miss qualifier to memory, asserted with mem_rd_en
mem_wr_en  out  1  word-write request to memory
mem_addr  out  ADDR_W  memory address (line base for reads, word for writes)
mem_wdata  out  32  write data
mem_rdata  in  128  line data, word0 in [31:0]
mem_ready  in  1  one-cycle completion pulse from memory
hit_cnt  out  CNT_W  read hits, saturating
miss_cnt  out  CNT_W  read misses, saturating

Behaviour:
- Address split:
  - offset = addr[1:0]
  - index = addr[INDEX_W+1:2]
  - tag = addr[ADDR_W-1:INDEX_W+2]
  - hit = valid[index] & (tag_arr[index] == tag)
- Reset (RST low, async):
  - state = IDLE; all valid bits = 0.
  - mem_rd_en, mem_miss, mem_wr_en = 0; mem_addr = 0; mem_wdata = 0.
  - hit_cnt, miss_cnt = 0.
  - Data/tag arrays are not cleared.
  - Reset mid-fill or mid-write abandons the transaction; the line stays invalid.
- States:
  - IDLE:
    - cpu_wr has priority over cpu_rd; a simultaneous cpu_rd is ignored until cpu_wr completes.
    - cpu_wr -> WRITE. Register mem_addr = cpu_addr and mem_wdata = cpu_wdata, set mem_wr_en = 1.
    - cpu_rd & hit -> stay IDLE. Drive cpu_rdata = data[index][offset] combinationally, stall = 0, hit_cnt += 1.
    - cpu_rd & ~hit -> FILL. Register mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00}, set mem_rd_en = mem_miss = 1, miss_cnt += 1.
    - flush with no cpu_rd/cpu_wr -> all valid = 0 in one cycle.
    - mem_ready in IDLE is ignored.
  - FILL:
    - mem_rd_en and mem_miss are held high.
    - On mem_ready: write mem_rdata to data[index], tag_arr[index] = tag, valid[index] = 1; drop mem_rd_en/mem_miss; -> IDLE.
    - The same load then hits the following cycle. It is not re-counted, so a miss never also increments hit_cnt: suppress the hit count on the first IDLE cycle after FILL.
  - WRITE:
    - mem_wr_en is held high.
    - On mem_ready: drop mem_wr_en.
      - If hit (same address), update data[index][offset] = mem_wdata.
      - A miss leaves the cache untouched.
      - -> WDONE.
  - WDONE: one cycle with stall = 0 to retire the store; the core advances; -> IDLE.
- stall (combinational):
  - 1 in FILL and in WRITE.
  - 1 in IDLE when cpu_wr, or when cpu_rd & ~hit.
  - 0 otherwise.
- Latency:
  - Read hit: 0 wait cycles.
  - Read miss: 1 (request) + N cycles until mem_ready + 1 (IDLE hit) with stall high for 1+N.
  - Store: stall high from request through the mem_ready cycle, low in WDONE.
- cpu_rdata = 0 when not (cpu_rd & hit & IDLE).
- Counters saturate at all-ones (no wrap).
- Arbitrary mem_ready latency is supported (no timeout).
- Two mem_ready pulses inside one transaction: only the first is acted on.

Test Plan:
- Reset, then load addr 0x004 (cold) -> stall=1; mem_rd_en=mem_miss=1; mem_addr=0x004. Memory returns line {4,3,2,1} after 4 cycles -> next cycle cpu_rdata=1, stall=0; miss_cnt=1, hit_cnt=0.
- Loads to 0x005, 0x007 after that fill -> zero-stall hits, cpu_rdata=2 then 4; hit_cnt=2; no mem_rd_en.
- Store 0xDEADBEEF to 0x006 (resident) -> mem_wr_en held until mem_ready; stall low exactly one cycle (WDONE). A following load of 0x006 hits and returns 0xDEADBEEF.
- Store to 0x084 (same index as 0x004, different tag) -> memory written; a load of 0x004 still hits, and valid/tag are unchanged. Then load 0x084 -> miss, refill replaces line; a load of 0x004 then misses.
- cpu_rd and cpu_wr together on 0x010 -> write sequence only, no mem_rd_en during it. flush in IDLE -> next load of 0x005 misses.
- Assert RST mid-FILL (2 cycles after mem_rd_en) -> outputs zero immediately; after release, a load of the same address misses again. Preload miss_cnt near all-ones -> it saturates at 0xFFFF.
